// File: rtl/modulo_abastecedor_rolhas.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : modulo_abastecedor_rolhas
//  Description : Cork feeder for the capping station. Keeps a main cork
//                buffer topped up from a secondary store, and accepts
//                operator loads into that store.
//                When the main buffer falls to MIN_MAIN or below, it is
//                refilled one cork per cycle until it is full or the store
//                is empty.
//  Ports       : clk        system clock
//                clr        synchronous active-high reset
//                en         line running; gates refill only
//                ve         one cork consumed this cycle
//                add_valid  operator load request
//                add_qty    corks to load (7-bit unsigned)
//                main_cnt   main buffer count (0..MAX_MAIN)
//                sec_cnt    secondary store count (0..MAX_SEC)
//                ro         main buffer empty
//                min_flag   main buffer at or below MIN_MAIN
//                add_ack    one-cycle pulse, load accepted
//                add_err    one-cycle pulse, load rejected
//                estado     FSM state: 00 IDLE, 01 REFILL, 10 DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module modulo_abastecedor_rolhas #(
  parameter int MAX_MAIN = 20,
  parameter int MIN_MAIN = 5,
  parameter int MAX_SEC  = 99
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       ve,
  input  logic       add_valid,
  input  logic [6:0] add_qty,
  output logic [6:0] main_cnt,
  output logic [6:0] sec_cnt,
  output logic       ro,
  output logic       min_flag,
  output logic       add_ack,
  output logic       add_err,
  output logic [1:0] estado
);

  localparam logic [1:0] C_ST_IDLE   = 2'b00;
  localparam logic [1:0] C_ST_REFILL = 2'b01;
  localparam logic [1:0] C_ST_DONE   = 2'b10;

  localparam logic [6:0] C_MAX_MAIN = 7'(MAX_MAIN);
  localparam logic [6:0] C_MIN_MAIN = 7'(MIN_MAIN);
  localparam logic [7:0] C_MAX_SEC  = 8'(MAX_SEC);

  logic [1:0] state_q, state_d;
  logic [6:0] main_q,  main_d;
  logic [6:0] sec_q,   sec_d;
  logic       ack_q,   ack_d;
  logic       err_q,   err_d;

  logic       w_refill_go;
  logic       w_xfer;
  logic       w_ve_eff;
  logic [7:0] w_sum;
  logic       w_load_ok;

  // --------------------------------------------------------------------------
  // State and counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= C_ST_IDLE;
      main_q  <= 7'd0;
      sec_q   <= 7'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      sec_q   <= sec_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_refill_go = en && (main_q <= C_MIN_MAIN) && (sec_q != 7'd0);
    // The bounds checks keep the counters from wrapping even if the FSM were
    // ever to sit in REFILL with nothing left to move.
    w_xfer      = (state_q == C_ST_REFILL) && en && (sec_q != 7'd0) &&
                  (main_q < C_MAX_MAIN);
    // Consumption from an empty buffer is simply ignored.
    w_ve_eff    = ve && (main_q != 7'd0);

    // Sum is one bit wider so an overflowing load is detected, not wrapped.
    w_sum       = {1'b0, sec_q} + {1'b0, add_qty};
    w_load_ok   = add_valid && (state_q != C_ST_REFILL) && (w_sum <= C_MAX_SEC);

    // A transfer and a consumption in the same cycle cancel on main_cnt.
    main_d = main_q;
    if (w_xfer && !w_ve_eff) begin
      main_d = main_q + 7'd1;
    end else if (!w_xfer && w_ve_eff) begin
      main_d = main_q - 7'd1;
    end

    // Loads are never accepted during REFILL, so they cannot collide with a
    // transfer on sec_cnt.
    sec_d = sec_q;
    if (w_xfer) begin
      sec_d = sec_q - 7'd1;
    end else if (w_load_ok) begin
      sec_d = w_sum[6:0];
    end

    ack_d = w_load_ok;
    err_d = add_valid && !w_load_ok;

    state_d = state_q;
    case (state_q)
      C_ST_IDLE: begin
        if (w_refill_go) begin
          state_d = C_ST_REFILL;
        end
      end
      C_ST_REFILL: begin
        if (!w_xfer) begin
          state_d = C_ST_IDLE;
        end else if ((main_d == C_MAX_MAIN) || (sec_d == 7'd0)) begin
          state_d = C_ST_DONE;
        end
      end
      C_ST_DONE: begin
        state_d = C_ST_IDLE;
      end
      default: begin
        state_d = C_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    estado   = state_q;
    main_cnt = main_q;
    sec_cnt  = sec_q;
    add_ack  = ack_q;
    add_err  = err_q;
    ro       = (main_q == 7'd0);
    min_flag = (main_q <= C_MIN_MAIN);
  end

endmodule
`default_nettype wire
